// File: rtl/jacobi_pkg.sv
// rtl/jacobi_pkg.sv - shared states, default sizes and helpers for the Jacobi scan sequencer
package jacobi_pkg;

  localparam int JACOBI_WIDTH  = 8;
  localparam int JACOBI_NODES  = 16;
  localparam int JACOBI_CWIDTH = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    UNLOAD = 2'd3
  } state_t;

  // Number of bits needed to hold values 0..value-1
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/jacobi_seq_downcount.sv
// rtl/jacobi_seq_downcount.sv - loadable iteration down-counter that stops at zero
module jacobi_seq_downcount #(
  parameter int CWIDTH = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [CWIDTH-1:0] load_value,
  input  logic              dec,
  output logic [CWIDTH-1:0] count,
  output logic              zero
);

  // Load wins over decrement; decrement is ignored once the count reaches zero
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/jacobi_scan_sequencer.sv
// rtl/jacobi_scan_sequencer.sv - load/run/unload sequencer for the Jacobi scan chain (option: JACOBI_SEQ_RECIRC_EN)
module jacobi_scan_sequencer
  import jacobi_pkg::*;
#(
  parameter int WIDTH  = JACOBI_WIDTH,
  parameter int NODES  = JACOBI_NODES,
  parameter int CWIDTH = JACOBI_CWIDTH
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [CWIDTH-1:0] IterCount,
  input  logic [WIDTH-1:0]  InData,
  input  logic              InValid,
  output logic              InReady,
  output logic [WIDTH-1:0]  OutData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [WIDTH-1:0]  ScanHeadOut,
  input  logic [WIDTH-1:0]  ScanTailIn,
  output logic              ScanEnable,
  output logic              Enable,
  output logic              Busy,
  output logic              Done
);

  localparam int IDX_W = clog2(NODES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NODES - 1);

  state_t            state;
  state_t            state_next;
  logic [IDX_W-1:0]  idx;
  logic              idx_clr;
  logic              idx_inc;
  logic              iter_load;
  logic              iter_dec;
  logic [CWIDTH-1:0] iter_count;
  logic              iter_zero;
  logic              enable_next;
  logic              done_next;

  jacobi_seq_downcount #(
    .CWIDTH(CWIDTH)
  ) u_iter (
    .clk       (Clk),
    .reset     (Reset),
    .load      (iter_load),
    .load_value(IterCount),
    .dec       (iter_dec),
    .count     (iter_count),
    .zero      (iter_zero)
  );

  // State, word index and the registered status outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      idx    <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      Enable <= 1'b0;
    end else begin
      state  <= state_next;
      Busy   <= (state_next != IDLE);
      Done   <= done_next;
      Enable <= enable_next;
      if (idx_clr) begin
        idx <= '0;
      end else if (idx_inc) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Next state, counter controls and the zero-latency stream/scan muxing
  always_comb begin
    state_next  = state;
    idx_clr     = 1'b0;
    idx_inc     = 1'b0;
    iter_load   = 1'b0;
    iter_dec    = 1'b0;
    enable_next = 1'b0;
    InReady     = 1'b0;
    OutValid    = 1'b0;
    OutData     = '0;
    ScanHeadOut = '0;
    ScanEnable  = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          state_next = LOAD;
          iter_load  = 1'b1;
          idx_clr    = 1'b1;
        end
      end
      LOAD: begin
        InReady     = 1'b1;
        ScanHeadOut = InData;
        ScanEnable  = InValid;
        if (InValid) begin
          if (idx == IDX_LAST) begin
            state_next  = RUN;
            idx_clr     = 1'b1;
            // First RUN cycle computes only if a nonzero count was latched
            enable_next = !iter_zero;
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
      RUN: begin
        if (iter_zero) begin
          state_next = UNLOAD;
        end else begin
          iter_dec    = 1'b1;
          // Stay enabled while the decremented count is still nonzero
          enable_next = (iter_count != CWIDTH'(1));
        end
      end
      UNLOAD: begin
        OutValid   = 1'b1;
        OutData    = ScanTailIn;
`ifdef JACOBI_SEQ_RECIRC_EN
        ScanHeadOut = ScanTailIn;
`else
        ScanHeadOut = '0;
`endif
        ScanEnable = OutReady;
        if (OutReady) begin
          if (idx == IDX_LAST) begin
            state_next = IDLE;
            idx_clr    = 1'b1;
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    done_next = (state == UNLOAD) && (state_next == IDLE);
  end

endmodule

// File: tb/tb_jacobi_scan_sequencer.sv
// tb/tb_jacobi_scan_sequencer.sv - directed bench with a 16-node scan array model (4x4 grid)
module tb_jacobi_scan_sequencer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [6:0] IterCount;
  logic [7:0] InData;
  logic       InValid;
  logic       InReady;
  logic [7:0] OutData;
  logic       OutValid;
  logic       OutReady;
  logic [7:0] ScanHeadOut;
  logic [7:0] ScanTailIn;
  logic       ScanEnable;
  logic       Enable;
  logic       Busy;
  logic       Done;

  logic [7:0] node [16];

  int n_checks = 0;
  int n_pass   = 0;

  int en_cycles = 0, run_cycles = 0, done_cnt = 0, load_sh = 0, unload_sh = 0;
  int hs_err = 0, both_err = 0, stab_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always #5 Clk = ~Clk;

  jacobi_scan_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .IterCount(IterCount),
    .InData(InData), .InValid(InValid), .InReady(InReady),
    .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady),
    .ScanHeadOut(ScanHeadOut), .ScanTailIn(ScanTailIn), .ScanEnable(ScanEnable),
    .Enable(Enable), .Busy(Busy), .Done(Done)
  );

  assign ScanTailIn = node[0];

  // Array model: shift toward node 0 on ScanEnable, else one Jacobi step on interior cells
  always @(posedge Clk) begin
    if (ScanEnable === 1'b1) begin
      for (int i = 0; i < 15; i++) node[i] <= node[i+1];
      node[15] <= ScanHeadOut;
    end else if (Enable === 1'b1) begin
      for (int r = 1; r < 3; r++) begin
        for (int c = 1; c < 3; c++) begin
          int s;
          s = int'(node[(r-1)*4+c]) + int'(node[(r+1)*4+c]) + int'(node[r*4+c-1]) + int'(node[r*4+c+1]);
          node[r*4+c] <= 8'(s >> 2);
        end
      end
    end
  end

  // Per-cycle protocol monitor, sampled mid-way through the low clock phase
  always @(negedge Clk) begin
    #3;
    if (Enable === 1'b1) en_cycles++;
    if (Busy === 1'b1 && InReady === 1'b0 && OutValid === 1'b0) run_cycles++;
    if (Done === 1'b1) done_cnt++;
    if (ScanEnable === 1'b1 && InReady === 1'b1) load_sh++;
    if (ScanEnable === 1'b1 && OutValid === 1'b1) unload_sh++;
    if (ScanEnable !== ((InValid && InReady) || (OutValid && OutReady))) hs_err++;
    if (ScanEnable === 1'b1 && Enable === 1'b1) both_err++;
    if (prev_stall && OutValid === 1'b1 && OutData !== prev_data) stab_err++;
    prev_stall = (OutValid === 1'b1) && (OutReady === 1'b0);
    prev_data  = OutData;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called at a negedge; leaves the bench at a negedge with Start low and the DUT in LOAD
  task automatic start_pass(input logic [6:0] iters);
    Start = 1'b1;
    IterCount = iters;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic load_words(input logic [7:0] w[16], input int count, input bit stall, input string tag);
    int i = 0;
    int guard = 0;
    while (i < count && guard < 2000) begin
      InValid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      InData  = w[i];
      #1;
      if (InValid && InReady) i++;
      @(negedge Clk);
      guard++;
    end
    InValid = 1'b0;
    check({tag, "_load_count"}, i, count);
  endtask

  task automatic unload_words(output logic [7:0] got[16], input bit stall, input string tag);
    int i = 0;
    int guard = 0;
    for (int k = 0; k < 16; k++) got[k] = 8'h00;
    while (i < 16 && guard < 4000) begin
      OutReady = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (OutValid && OutReady) begin
        got[i] = OutData;
        i++;
      end
      @(negedge Clk);
      guard++;
    end
    OutReady = 1'b0;
    check({tag, "_unload_count"}, i, 16);
  endtask

  logic [7:0] w_in  [16];
  logic [7:0] w_out [16];
  int s_en, s_run, s_done, s_ld, s_ul, s_hs, s_stab;

  task automatic snap();
    s_en = en_cycles; s_run = run_cycles; s_done = done_cnt;
    s_ld = load_sh; s_ul = unload_sh; s_hs = hs_err; s_stab = stab_err;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b1; IterCount = 7'd0; InData = 8'h00; InValid = 1'b0; OutReady = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("t1_busy", Busy, 0);
    check("t1_inready", InReady, 0);
    check("t1_outvalid", OutValid, 0);
    check("t1_enable", Enable, 0);
    check("t1_scanenable", ScanEnable, 0);
    check("t1_done", Done, 0);
    Reset = 1'b0; Start = 1'b0;
    @(negedge Clk);

    // Back-to-back load, zero iterations: grid comes back unchanged
    for (int i = 0; i < 16; i++) w_in[i] = 8'h10 + 8'(i);
    snap();
    start_pass(7'd0);
    check("t2_busy", Busy, 1);
    load_words(w_in, 16, 1'b0, "t2");
    unload_words(w_out, 1'b0, "t2");
    repeat (2) @(negedge Clk);
    for (int i = 0; i < 16; i++) check($sformatf("t2_word%0d", i), w_out[i], 8'h10 + 8'(i));
    check("t2_run_cycles", run_cycles - s_run, 1);
    check("t2_enable_cycles", en_cycles - s_en, 0);
    check("t2_done_pulses", done_cnt - s_done, 1);
    check("t2_busy_after", Busy, 0);

    // Array contents left by the unload
    for (int i = 0; i < 16; i++) begin
`ifdef JACOBI_SEQ_RECIRC_EN
      check($sformatf("t6_node%0d", i), node[i], 8'h10 + 8'(i));
`else
      check($sformatf("t6_node%0d", i), node[i], 8'h00);
`endif
    end

    // 4x4 grid, boundary 0xFF, interior 0x40, 5 steps: 0x9F, 0xCF, 0xE7, 0xF3, 0xF9
    for (int i = 0; i < 16; i++) w_in[i] = 8'hFF;
    w_in[5] = 8'h40; w_in[6] = 8'h40; w_in[9] = 8'h40; w_in[10] = 8'h40;
    snap();
    start_pass(7'd5);
    load_words(w_in, 16, 1'b0, "t3");
    unload_words(w_out, 1'b0, "t3");
    repeat (2) @(negedge Clk);
    for (int i = 0; i < 16; i++) begin
      if (i == 5 || i == 6 || i == 9 || i == 10) check($sformatf("t3_node%0d", i), w_out[i], 8'hF9);
      else check($sformatf("t3_node%0d", i), w_out[i], 8'hFF);
    end
    check("t3_enable_cycles", en_cycles - s_en, 5);
    check("t3_run_cycles", run_cycles - s_run, 6);
    check("t3_done_pulses", done_cnt - s_done, 1);

    // Random stalls on both streams
    for (int i = 0; i < 16; i++) w_in[i] = 8'h20 + 8'(i * 3);
    snap();
    start_pass(7'd0);
    load_words(w_in, 16, 1'b1, "t4");
    unload_words(w_out, 1'b1, "t4");
    repeat (2) @(negedge Clk);
    for (int i = 0; i < 16; i++) check($sformatf("t4_word%0d", i), w_out[i], 8'h20 + 8'(i * 3));
    check("t4_load_shifts", load_sh - s_ld, 16);
    check("t4_unload_shifts", unload_sh - s_ul, 16);
    check("t4_handshake_errs", hs_err - s_hs, 0);
    check("t4_stable_errs", stab_err - s_stab, 0);

    // Reset part-way through a load, then a clean pass
    for (int i = 0; i < 16; i++) w_in[i] = 8'hA0 + 8'(i);
    start_pass(7'd0);
    load_words(w_in, 7, 1'b0, "t5a");
    Reset = 1'b1;
    @(negedge Clk);
    check("t5_busy_reset", Busy, 0);
    check("t5_inready_reset", InReady, 0);
    Reset = 1'b0;
    @(negedge Clk);
    snap();
    start_pass(7'd0);
    load_words(w_in, 16, 1'b0, "t5b");
    unload_words(w_out, 1'b0, "t5b");
    repeat (2) @(negedge Clk);
    for (int i = 0; i < 16; i++) check($sformatf("t5_word%0d", i), w_out[i], 8'hA0 + 8'(i));
    check("t5_done_pulses", done_cnt - s_done, 1);

    check("all_enable_scan_overlap", both_err, 0);
    check("all_handshake_errs", hs_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
